// File: rtl/mem_arbiter.sv
// Two-port round-robin front end for a single-port Mem: one request in flight at a time,
// registered Mem strobes, read data captured and held on a per-port valid/ready response.
module mem_arbiter #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  logic                 m0_req_we,
  input  logic [ADDR_BITS-1:0] m0_req_addr,
  input  logic [DATA_BITS-1:0] m0_req_wdata,
  output logic                 m0_resp_valid,
  input  logic                 m0_resp_ready,
  output logic [DATA_BITS-1:0] m0_resp_rdata,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  logic                 m1_req_we,
  input  logic [ADDR_BITS-1:0] m1_req_addr,
  input  logic [DATA_BITS-1:0] m1_req_wdata,
  output logic                 m1_resp_valid,
  input  logic                 m1_resp_ready,
  output logic [DATA_BITS-1:0] m1_resp_rdata,
  input  logic                 clr_req,
  output logic                 clr_done,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_data_in,
  output logic                 mem_sel,
  output logic                 mem_ld,
  output logic                 mem_str,
  output logic                 mem_clr,
  input  logic [DATA_BITS-1:0] mem_data_out
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, CLEAR} state_t;

  state_t                     state;
  logic                       rr_ptr;
  logic                       own;
  logic                       lat_we;
  logic [1:0]                 resp_valid;
  logic [1:0][DATA_BITS-1:0]  resp_rdata;

  logic [1:0]                 vld;
  logic [1:0]                 rsp_rdy;
  logic                       gnt;
  logic                       can_grant;
  logic                       sel_we;
  logic [ADDR_BITS-1:0]       sel_addr;
  logic [DATA_BITS-1:0]       sel_wdata;

  assign vld     = {m1_req_valid, m0_req_valid};
  assign rsp_rdy = {m1_resp_ready, m0_resp_ready};

  // Preferred port wins if it is asking, otherwise the other one.
  always_comb begin
    gnt       = vld[rr_ptr] ? rr_ptr : ~rr_ptr;
    can_grant = (state == IDLE) && !clr_req && !clr_done && (|vld);
    sel_we    = gnt ? m1_req_we    : m0_req_we;
    sel_addr  = gnt ? m1_req_addr  : m0_req_addr;
    sel_wdata = gnt ? m1_req_wdata : m0_req_wdata;
  end

  assign m0_req_ready  = can_grant && !gnt;
  assign m1_req_ready  = can_grant &&  gnt;
  assign m0_resp_valid = resp_valid[0];
  assign m1_resp_valid = resp_valid[1];
  assign m0_resp_rdata = resp_rdata[0];
  assign m1_resp_rdata = resp_rdata[1];
  assign busy          = (state != IDLE);

  // Strobes are loaded on the edge entering ISSUE/CLEAR so they are clean for exactly one cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      own         <= 1'b0;
      lat_we      <= 1'b0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
      clr_done    <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_sel     <= 1'b0;
      mem_ld      <= 1'b0;
      mem_str     <= 1'b0;
      mem_clr     <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      mem_sel  <= 1'b0;
      mem_ld   <= 1'b0;
      mem_str  <= 1'b0;
      mem_clr  <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            mem_clr <= 1'b1;
            state   <= CLEAR;
          end else if (can_grant) begin
            own      <= gnt;
            lat_we   <= sel_we;
            rr_ptr   <= ~gnt;
            mem_sel  <= 1'b1;
            mem_ld   <= ~sel_we;
            mem_str  <= sel_we;
            mem_addr <= sel_addr;
            if (sel_we) mem_data_in <= sel_wdata;
            state    <= ISSUE;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: begin
          resp_rdata[own] <= lat_we ? '0 : mem_data_out;
          resp_valid[own] <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (rsp_rdy[own]) begin
            resp_valid[own] <= 1'b0;
            state           <= IDLE;
          end
        end
        CLEAR: begin
          clr_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural Mem and a response scoreboard.
module tb_mem_arbiter;

  logic                   clk = 1'b0;
  logic                   clr_n = 1'b0;
  logic [1:0]             req_valid = '0, req_we = '0, rsp_ready = '1;
  logic [1:0][9:0]        req_addr = '0;
  logic [1:0][31:0]       req_wdata = '0;
  logic [1:0]             req_ready, rv;
  logic [1:0][31:0]       rd;
  logic                   clr_req = 1'b0;
  logic                   clr_done, busy;
  logic [9:0]             mem_addr;
  logic [31:0]            mem_data_in;
  logic                   mem_sel, mem_ld, mem_str, mem_clr;
  wire  [31:0]            mem_data_out;

  int total = 0;
  int bad   = 0;

  typedef struct { bit p; logic [31:0] d; } exp_t;
  exp_t        sbq[$];
  logic [31:0] exp_mem [1024];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_BITS(10), .DATA_BITS(32)) dut (
    .clk(clk), .clr_n(clr_n),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_we(req_we[0]),
    .m0_req_addr(req_addr[0]), .m0_req_wdata(req_wdata[0]),
    .m0_resp_valid(rv[0]), .m0_resp_ready(rsp_ready[0]), .m0_resp_rdata(rd[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_we(req_we[1]),
    .m1_req_addr(req_addr[1]), .m1_req_wdata(req_wdata[1]),
    .m1_resp_valid(rv[1]), .m1_resp_ready(rsp_ready[1]), .m1_resp_rdata(rd[1]),
    .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_sel(mem_sel), .mem_ld(mem_ld), .mem_str(mem_str), .mem_clr(mem_clr),
    .mem_data_out(mem_data_out)
  );

  // Behavioural single-port Mem: read data valid the cycle after the ld strobe, else z.
  logic [31:0] mem_arr [1024];
  logic        rd_v = 1'b0;
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
    end else if (mem_sel && mem_str) begin
      mem_arr[mem_addr] <= mem_data_in;
    end
    rd_v <= mem_sel && mem_ld;
    rd_q <= mem_arr[mem_addr];
  end
  assign mem_data_out = rd_v ? rd_q : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read and write strobes must never be active together.
  always @(negedge clk) if (clr_n && (mem_ld || mem_str)) chk("ld_str_excl", 32'(mem_ld & mem_str), 32'd0);

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rv"},    32'(rv),        32'd0);
    chk({tag, "_rd0"},   rd[0],          32'd0);
    chk({tag, "_rd1"},   rd[1],          32'd0);
    chk({tag, "_strb"},  32'({mem_sel, mem_ld, mem_str, mem_clr, clr_done, busy}), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_din"},   mem_data_in,    32'd0);
  endtask

  // One request through the full handshake, with a given number of response back-pressure cycles.
  task automatic do_req(input bit p, input bit we, input logic [9:0] a, input logic [31:0] d,
                        input int hold);
    int   n;
    exp_t e;
    req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = d;
    rsp_ready[p] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready[p] && n < 20) begin @(negedge clk); n++; end
    chk("req_accept", 32'(req_ready[p]), 32'd1);
    e.p = p;
    e.d = we ? 32'd0 : exp_mem[a];
    if (we) exp_mem[a] = d;
    sbq.push_back(e);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    @(negedge clk);
    chk("issue_rv", 32'(rv), 32'd0);
    chk("issue_strb", 32'({mem_sel, mem_ld, mem_str}), 32'({1'b1, ~we, we}));
    chk("issue_addr", 32'(mem_addr), 32'(a));
    if (we) chk("issue_din", mem_data_in, d);
    @(negedge clk);
    chk("capt_rv", 32'(rv), 32'd0);
    chk("capt_strb", 32'({mem_sel, mem_ld, mem_str, mem_clr}), 32'd0);
    @(negedge clk);
    e = sbq.pop_front();
    chk("resp_rv", 32'(rv), e.p ? 32'd2 : 32'd1);
    chk("resp_rdata", rd[e.p], e.d);
    for (int i = 0; i < hold; i++) begin
      chk("hold_rv", 32'(rv[p]), 32'd1);
      chk("hold_rdata", rd[p], e.d);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_nogrant", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    chk("resp_exit_rv", 32'(rv), 32'd0);
    chk("resp_exit_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int   grants, cyc;
    bit   p;
    exp_t e;

    // Reset state
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;

    // Write then read back 0xDEADBEEF on m0
    do_req(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 0);
    do_req(1'b0, 1'b0, 10'h005, 32'h0, 0);

    // Top address through m1, write response carries zero
    do_req(1'b1, 1'b1, 10'h3FF, 32'h12345678, 0);
    do_req(1'b1, 1'b0, 10'h3FF, 32'h0, 0);

    // Response back-pressure for five cycles
    do_req(1'b1, 1'b0, 10'h005, 32'h0, 5);

    // Fresh reset then both ports requesting continuously must alternate m0,m1,m0,m1
    clr_n = 1'b0; #1 clr_n = 1'b1;
    @(posedge clk); #1;
    req_we = '0; req_addr[0] = 10'h005; req_addr[1] = 10'h3FF;
    req_valid = 2'b11; rsp_ready = 2'b11;
    grants = 0; cyc = 0;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (req_ready != 2'b00) begin
        p = req_ready[1];
        chk("rr_onehot", 32'(req_ready[0] & req_ready[1]), 32'd0);
        chk("rr_order", 32'(p), 32'(grants % 2));
        e.p = p; e.d = exp_mem[req_addr[p]];
        sbq.push_back(e);
        grants++;
        if (grants == 4) begin @(posedge clk); #1 req_valid = 2'b00; end
      end
      for (int q = 0; q < 2; q++) if (rv[q] && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rr_port", 32'(q), 32'(e.p));
        chk("rr_rdata", rd[q], e.d);
      end
    end
    chk("rr_grants", 32'(grants), 32'd4);
    cyc = 0;
    while (sbq.size() > 0 && cyc < 10) begin
      @(negedge clk); cyc++;
      for (int q = 0; q < 2; q++) if (rv[q] && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rr_port", 32'(q), 32'(e.p));
        chk("rr_rdata", rd[q], e.d);
      end
    end
    chk("rr_drained", 32'(sbq.size()), 32'd0);

    // Clear has priority over a same-cycle request
    @(posedge clk); #1;
    clr_req = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 10'h3FF;
    @(negedge clk);
    chk("clr_noready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("clr_strobe", 32'({mem_clr, mem_sel, mem_ld, mem_str}), 32'b1000);
    chk("clr_busy", 32'(busy), 32'd1);
    clr_req = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    @(posedge clk); #1;
    chk("clr_done", 32'({clr_done, mem_clr}), 32'b10);
    chk("clr_done_nogrant", 32'(req_ready), 32'd0);
    do_req(1'b0, 1'b0, 10'h3FF, 32'h0, 0);
    chk("clr_done_pulse", 32'(clr_done), 32'd0);

    // Reset asserted during CAPTURE drops the in-flight request
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 10'h005;
    cyc = 0;
    @(negedge clk);
    while (!req_ready[1] && cyc < 20) begin @(negedge clk); cyc++; end
    chk("rst5_accept", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b0; #1;
    check_reset_outputs("rst5");
    @(posedge clk); #1 clr_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst5_no_resp", 32'({rv, busy}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
